fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_addr  output  32  instruction memory byte address (current PC).
REQ-005 SHALL have port imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 SHALL have port stall  input  1  hazard hold request from downstream.
REQ-007 SHALL have port redirect_valid  input  1  resolved taken branch or jump from downstream.
REQ-008 SHALL have port redirect_target  input  32  new PC for a redirect.
REQ-009 SHALL have port if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-010 SHALL have port if_id_instr  output  32  latched instruction word.
REQ-011 SHALL have port if_id_pc4  output  32  latched address of instruction plus 4.
REQ-012 SHALL have port opcode  output  6  if_id_instr[31:26], feeding the control unit.
REQ-013 SHALL have port rs, rt, rd  output  5 each  if_id_instr[25:21], [20:16], [15:11].
REQ-014 SHALL have port imm_ext  output  32  if_id_instr[15:0] sign-extended.
REQ-015 SHALL have port jump_target  output  32  {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
REQ-016 SHALL have port fetch_count  output  32  number of instructions latched valid since reset.

Function
REQ-017 SHALL drive imem_addr combinationally from the PC register, with zero added latency.
REQ-018 SHALL derive opcode, rs, rt, rd, imm_ext, jump_target combinationally from the IF/ID register only.
REQ-019 SHALL, per cycle, apply priority: reset > redirect_valid > stall > normal advance.
REQ-020 SHALL, on normal advance: PC <= PC+4; if_id_instr <= imem_rdata; if_id_pc4 <= PC+4; if_id_valid <= 1; fetch_count <= fetch_count+1.
REQ-021 SHALL, on stall without redirect: hold PC, the IF/ID register and fetch_count unchanged.
REQ-022 SHALL, on redirect_valid (stall ignored): PC <= {redirect_target[31:2], 2'b00}; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0; fetch_count unchanged.
REQ-023 SHALL force PC bits [1:0] to 00 at all times; misaligned targets are truncated, no error raised.
REQ-024 SHALL compute PC+4 modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 SHALL wrap fetch_count modulo 2^32 without saturation.
REQ-026 SHALL present a flushed bubble as instruction 32'h0000_0000 (opcode 6'b000000, writes only $0, architecturally a no-op).
REQ-027 SHALL latch imem_rdata as given, performing no opcode validity checks.
REQ-028 SHALL, when redirect_valid and stall rise together in consecutive cycles, apply each cycle independently per REQ-019.

Reset
REQ-029 SHALL, on reset high at a clock edge: PC <= RESET_PC; if_id_instr <= 0; if_id_pc4 <= 0; if_id_valid <= 0; fetch_count <= 0.
REQ-030 SHALL let reset override a concurrent stall or redirect, including mid-stall.
REQ-031 SHALL produce the first valid fetch from RESET_PC on the first edge after reset deasserts.

Verification
REQ-032 SHALL pass: reset, then 3 edges with memory words 8C01_0004, 2002_0005, 0000_0000 at 0x0,0x4,0x8 -> if_id_instr sequence 8C01_0004, 2002_0005, 0; opcode 100011 then 001000; if_id_pc4 4, 8, C; fetch_count 3.
REQ-033 SHALL pass: stall high 2 cycles with PC=0x8 -> imem_addr stays 0x8, IF/ID and fetch_count unchanged, resume fetches 0x8 next.
REQ-034 SHALL pass: redirect_valid with target 0x0000_0043 and stall both high -> PC 0x40, if_id_valid 0, if_id_instr 0, fetch_count unchanged.
REQ-035 SHALL pass: PC 0xFFFF_FFFC, normal advance -> PC 0x0, if_id_pc4 0x0; instr 0800_0010 gives jump_target 0x0000_0040.
REQ-036 SHALL pass: instr 2003_FFFF latched -> imm_ext 0xFFFF_FFFF, rs 0, rt 3; instr 3003_7FFF -> imm_ext 0x0000_7FFF.
REQ-037 SHALL pass: reset asserted mid-stall after 5 fetches -> next edge PC=RESET_PC, if_id_valid 0, fetch_count 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC. Presents it to instruction memory combinationally, then
// latches the returned word together with PC+4 into the IF/ID register.
// The instruction fields that the decode stage needs are split out
// combinationally from the IF/ID register.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   synchronous, active-high
//   imem_addr        out  [31:0] byte address of the current PC
//   imem_rdata       in   [31:0] instruction word for imem_addr (same cycle)
//   stall            in   hold PC, IF/ID and fetch_count
//   redirect_valid   in   taken branch/jump; flushes IF/ID, overrides stall
//   redirect_target  in   [31:0] new PC (low two bits dropped)
//   if_id_valid      out  IF/ID holds a real instruction
//   if_id_instr      out  [31:0] latched instruction
//   if_id_pc4        out  [31:0] latched instruction address + 4
//   opcode           out  [5:0]  if_id_instr[31:26]
//   rs, rt, rd       out  [4:0]  if_id_instr[25:21], [20:16], [15:11]
//   imm_ext          out  [31:0] sign-extended if_id_instr[15:0]
//   jump_target      out  [31:0] {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}
//   fetch_count      out  [31:0] valid instructions latched since reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_ext,
    output logic [31:0] jump_target,
    output logic [31:0] fetch_count
);

    // Only the word-aligned part of the PC is stored, so the low two bits
    // are zero by construction for reset, redirect and increment alike.
    logic [29:0] pc_word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc        = {pc_word, 2'b00};
    assign pc_plus4  = pc + 32'd4;   // wraps naturally at 2^32
    assign imem_addr = pc;

    // Priority: reset > redirect > stall > advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_word     <= RESET_PC[31:2];
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            fetch_count <= 32'h0;
        end else if (redirect_valid) begin
            // Flush to an all-zero bubble, which decodes as a no-op.
            pc_word     <= redirect_target[31:2];
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else if (!stall) begin
            pc_word     <= pc_plus4[31:2];
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // Decode fields come from the IF/ID register only, never from imem_rdata.
    assign opcode      = if_id_instr[31:26];
    assign rs          = if_id_instr[25:21];
    assign rt          = if_id_instr[20:16];
    assign rd          = if_id_instr[15:11];
    assign imm_ext     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [31:0] jump_target;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd),
        .imm_ext(imm_ext), .jump_target(jump_target),
        .fetch_count(fetch_count)
    );

    // Small instruction memory, indexed by word address bits [7:2].
    logic [31:0] mem [0:63];
    assign imem_rdata = mem[imem_addr[7:2]];

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] jt;
    } vec_t;

    vec_t vecs [0:31];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic s, input logic d, input logic [31:0] t,
                     input logic [31:0] a, input logic vl, input logic [31:0] ins,
                     input logic [31:0] p4, input logic [31:0] c, input logic [5:0] o,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                     input logic [31:0] im, input logic [31:0] j);
        vecs[nvec] = '{r, s, d, t, a, vl, ins, p4, c, o, s1, s2, s3, im, j};
        nvec++;
    endtask

    task automatic check_all(input int idx, input vec_t e);
        chk("imem_addr",   idx, imem_addr,           e.addr);
        chk("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, e.vld});
        chk("if_id_instr", idx, if_id_instr,         e.instr);
        chk("if_id_pc4",   idx, if_id_pc4,           e.pc4);
        chk("fetch_count", idx, fetch_count,         e.cnt);
        chk("opcode",      idx, {26'b0, opcode},     {26'b0, e.op});
        chk("rs",          idx, {27'b0, rs},         {27'b0, e.rs});
        chk("rt",          idx, {27'b0, rt},         {27'b0, e.rt});
        chk("rd",          idx, {27'b0, rd},         {27'b0, e.rd});
        chk("imm_ext",     idx, imm_ext,             e.imm);
        chk("jump_target", idx, jump_target,         e.jt);
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(negedge clk);
        reset = r; stall = s; redirect_valid = d; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h8C01_0004;
        mem[1]  = 32'h2002_0005;
        mem[2]  = 32'h0000_0000;
        mem[3]  = 32'h2003_FFFF;
        mem[4]  = 32'h3003_7FFF;
        mem[16] = 32'h0800_0010;   // 0x40
        mem[63] = 32'h0800_0010;   // 0xFFFF_FFFC

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

        //  rst stl rdr target        addr          vld instr          pc4           cnt    op     rs rt rd  imm            jt
        v(1, 0, 0, 32'h0,         32'h0000_0000, 0, 32'h0,         32'h0,         32'd0, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h8C01_0004, 32'h0000_0004, 32'd1, 6'h23, 0, 1, 0,  32'h0000_0004, 32'h0004_0010);
        v(0, 0, 0, 32'h0,         32'h0000_0008, 1, 32'h2002_0005, 32'h0000_0008, 32'd2, 6'h08, 0, 2, 0,  32'h0000_0005, 32'h0008_0014);
        // two stall cycles with PC = 0x8
        v(0, 1, 0, 32'h0,         32'h0000_0008, 1, 32'h2002_0005, 32'h0000_0008, 32'd2, 6'h08, 0, 2, 0,  32'h0000_0005, 32'h0008_0014);
        v(0, 1, 0, 32'h0,         32'h0000_0008, 1, 32'h2002_0005, 32'h0000_0008, 32'd2, 6'h08, 0, 2, 0,  32'h0000_0005, 32'h0008_0014);
        v(0, 0, 0, 32'h0,         32'h0000_000C, 1, 32'h0000_0000, 32'h0000_000C, 32'd3, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h2003_FFFF, 32'h0000_0010, 32'd4, 6'h08, 0, 3, 31, 32'hFFFF_FFFF, 32'h000F_FFFC);
        v(0, 0, 0, 32'h0,         32'h0000_0014, 1, 32'h3003_7FFF, 32'h0000_0014, 32'd5, 6'h0C, 0, 3, 15, 32'h0000_7FFF, 32'h000D_FFFC);
        // misaligned redirect together with stall
        v(0, 1, 1, 32'h0000_0043, 32'h0000_0040, 0, 32'h0,         32'h0,         32'd5, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_0044, 1, 32'h0800_0010, 32'h0000_0044, 32'd6, 6'h02, 0, 0, 0,  32'h0000_0010, 32'h0000_0040);
        v(0, 1, 0, 32'h0,         32'h0000_0044, 1, 32'h0800_0010, 32'h0000_0044, 32'd6, 6'h02, 0, 0, 0,  32'h0000_0010, 32'h0000_0040);
        // reset mid-stall after six fetches
        v(1, 1, 0, 32'h0,         32'h0000_0000, 0, 32'h0,         32'h0,         32'd0, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h8C01_0004, 32'h0000_0004, 32'd1, 6'h23, 0, 1, 0,  32'h0000_0004, 32'h0004_0010);
        // redirect to top of memory, then wrap on advance
        v(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         32'd1, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_0000, 1, 32'h0800_0010, 32'h0000_0000, 32'd2, 6'h02, 0, 0, 0,  32'h0000_0010, 32'h0000_0040);
        // reset beats redirect
        v(1, 0, 1, 32'h0000_0080, 32'h0000_0000, 0, 32'h0,         32'h0,         32'd0, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        // redirect+stall, then stall alone: each cycle on its own
        v(0, 1, 1, 32'h0000_0008, 32'h0000_0008, 0, 32'h0,         32'h0,         32'd0, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 1, 0, 32'h0,         32'h0000_0008, 0, 32'h0,         32'h0,         32'd0, 6'h00, 0, 0, 0,  32'h0,         32'h0);
        v(0, 0, 0, 32'h0,         32'h0000_000C, 1, 32'h0000_0000, 32'h0000_000C, 32'd1, 6'h00, 0, 0, 0,  32'h0,         32'h0);

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
            check_all(i, vecs[i]);
        end

        // Back-to-back redirects: every one flushes, none counts a fetch.
        step(0, 0, 1, 32'h0000_0011);
        chk("redir_a_addr", 100, imem_addr, 32'h0000_0010);
        step(0, 0, 1, 32'h0000_0006);
        chk("redir_b_addr", 101, imem_addr, 32'h0000_0004);
        chk("redir_b_vld",  101, {31'b0, if_id_valid}, 32'h0);
        chk("redir_b_cnt",  101, fetch_count, 32'd1);
        // Combinational address follows PC before the edge.
        @(negedge clk);
        reset = 0; stall = 0; redirect_valid = 0;
        #1;
        chk("comb_rdata",   102, imem_rdata, 32'h2002_0005);
        @(posedge clk); #1;
        chk("resume_instr", 103, if_id_instr, 32'h2002_0005);
        chk("resume_pc4",   103, if_id_pc4, 32'h0000_0008);
        chk("resume_cnt",   103, fetch_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
